instr_encoder: RTL

Program-loading encoder, the write-side counterpart of the control decoder: it accepts symbolic instruction requests (operation, register fields, immediate), encodes them into 32-bit MIPS words with the same opcode/funct assignments the decoder and ALU control consume, and writes them sequentially into instruction memory. It sits between the testbench/boot loader and the instruction memory write port, ahead of the single-cycle CPU.

---
 rtl/instr_encoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Encodes symbolic ADD/SUB/AND/OR/SLT/BEQ/ADDI/SLTI requests into MIPS words
// and writes them sequentially into instruction memory until it is full.
module instr_encoder #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [4:0]            req_rs_i,
    input  logic [4:0]            req_rt_i,
    input  logic [4:0]            req_rd_i,
    input  logic [15:0]           req_imm_i,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic                  mem_ack_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH:0]   count_inc;

    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [5:0]  funct;
        logic [5:0]  opcode;
        logic [31:0] word;
        funct  = 6'h00;
        opcode = 6'h00;
        case (op)
            3'd0:    funct  = 6'h20;
            3'd1:    funct  = 6'h22;
            3'd2:    funct  = 6'h24;
            3'd3:    funct  = 6'h25;
            3'd4:    funct  = 6'h2A;
            3'd5:    opcode = 6'b000100;
            3'd6:    opcode = 6'b001000;
            default: opcode = 6'b001010;
        endcase
        if (op <= 3'd4) begin
            word = {6'b000000, rs, rt, rd, 5'b00000, funct};
        end else begin
            word = {opcode, rs, rt, imm};
        end
        return word;
    endfunction

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        // clear wins over everything, including an ack in the same cycle
        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        data_d  = encode(req_op_i, req_rs_i, req_rt_i, req_rd_i, req_imm_i);
                        addr_d  = count_q[ADDR_WIDTH-1:0];
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        count_d = count_inc;
                        state_d = (count_inc == DEPTH) ? FULL : IDLE;
                    end
                end
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Handshake outputs depend on state alone, never on valid/ack
    assign req_ready_o = (state_q == IDLE);
    assign mem_we_o    = (state_q == WRITE);
    assign mem_addr_o  = {{(30 - ADDR_WIDTH){1'b0}}, addr_q, 2'b00};
    assign mem_data_o  = data_q;
    assign count_o     = count_q;
    assign full_o      = (count_q == DEPTH);

endmodule
